// File: rtl/alu_mc_pkg.sv
// Opcode encodings and FSM state type shared by the multi-cycle ALU and its bench.
// No logic here; latency and backpressure live in alu_mc.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1100;
    localparam logic [3:0] OP_MULHU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc: master is the execute stage, slave the ALU.
// Both directions use valid/ready; a transfer happens when both are high at a clock edge.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             Overflow;
    logic             CarryOut;
    logic             Zero;

    modport master (
        output in_valid, A, B, ALUop, out_ready,
        input  in_ready, out_valid, Result, Overflow, CarryOut, Zero
    );

    modport slave (
        input  in_valid, A, B, ALUop, out_ready,
        output in_ready, out_valid, Result, Overflow, CarryOut, Zero
    );
endinterface

// File: rtl/alu_mc_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
// done pulses during the final step with product already including that step; no backpressure.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_step;

    always_comb begin
        acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
        last_step = busy_q && (cnt_q == CW'(WIDTH - 1));

        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;

        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last_step) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Exposing acc_next lets the caller capture the product on the last step edge.
    assign done    = last_step;
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: logic/arith/shift ops finish at the accept edge, MUL/MULHU WIDTH edges later.
// One op in flight; result is held in DONE until out_ready, and in_ready is low outside IDLE.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               hi_q, hi_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_cout;
    logic               sub;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [SHW-1:0]     shamt;
    logic               start_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    // Single-cycle unit: SUB reuses the adder as A + ~B + 1.
    always_comb begin
        sub      = (bus.ALUop == OP_SUB);
        b_eff    = sub ? ~bus.B : bus.B;
        sum      = {1'b0, bus.A} + {1'b0, b_eff} + (WIDTH + 1)'(sub);
        shamt    = bus.B[SHW-1:0];
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_cout = 1'b0;
        case (bus.ALUop)
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            OP_NOR:  alu_res = ~(bus.A | bus.B);
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (bus.A[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_SLL:  alu_res = bus.A << shamt;
            OP_SRL:  alu_res = bus.A >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(bus.A) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    assign start_mul = (state_q == IDLE) && bus.in_valid && is_mul(bus.ALUop);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul),
        .a       (bus.A),
        .b       (bus.B),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        cout_d   = cout_q;
        hi_d     = hi_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_mul(bus.ALUop)) begin
                        state_d = MULT;
                        hi_d    = (bus.ALUop == OP_MULHU);
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        cout_d   = alu_cout;
                    end
                end
            end
            MULT: begin
                if (mul_done) begin
                    state_d  = DONE;
                    result_d = hi_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
                    ovf_d    = 1'b0;
                    cout_d   = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b1;
            hi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Result    = result_q;
    assign bus.Overflow  = ovf_q;
    assign bus.CarryOut  = cout_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=32: vector table, model-checked random ops, handshake corner cases.
module tb_alu_mc;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        cout;
        logic        zero;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t sbq[$];
    vec_t tbl[$];

    alu_mc_if #(.WIDTH(32)) bus();

    alu_mc #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic ovf, input logic cout, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res;
        v.ovf = ovf; v.cout = cout; v.zero = (res == 32'h0); v.lat = lat;
        return v;
    endfunction

    // Reference model in 64-bit arithmetic, independent of the adder/shift-add structure.
    function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        longint unsigned ua, ub, p;
        longint sa, sbv, s;
        ua = {32'h0, a};
        ub = {32'h0, b};
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        v.op = op; v.a = a; v.b = b;
        v.res = 32'h0; v.ovf = 1'b0; v.cout = 1'b0; v.lat = 1;
        case (op)
            OP_AND:  v.res = a & b;
            OP_OR:   v.res = a | b;
            OP_XOR:  v.res = a ^ b;
            OP_NOR:  v.res = ~(a | b);
            OP_ADD: begin
                p = ua + ub;
                v.res = p[31:0];
                v.cout = p[32];
                s = sa + sbv;
                v.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                v.res = a - b;
                v.cout = (a >= b);
                s = sa - sbv;
                v.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SLT:  v.res = (sa < sbv) ? 32'd1 : 32'd0;
            OP_SLTU: v.res = (ua < ub) ? 32'd1 : 32'd0;
            OP_SLL:  v.res = a << b[4:0];
            OP_SRL:  v.res = a >> b[4:0];
            OP_SRA: begin
                s = sa >>> b[4:0];
                v.res = s[31:0];
            end
            OP_MUL: begin
                p = ua * ub;
                v.res = p[31:0];
                v.lat = 33;
            end
            OP_MULHU: begin
                p = ua * ub;
                v.res = p[63:32];
                v.lat = 33;
            end
            default: v.res = 32'h0;
        endcase
        v.zero = (v.res == 32'h0);
        return v;
    endfunction

    // Drive one op, push its expectation, wait (bounded) for out_valid, compare, then hand it off.
    task automatic run_op(input vec_t v, input string tag);
        vec_t e;
        int   lat;
        int   guard;
        bit   rdy_leak;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " in_ready"}, {31'h0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.A         = v.a;
        bus.B         = v.b;
        bus.ALUop     = v.op;
        bus.out_ready = 1'b1;
        sbq.push_back(v);
        @(posedge clk);
        lat = 0;
        rdy_leak = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'b0;
            if (bus.in_ready) rdy_leak = 1'b1;
        end while (!bus.out_valid && lat < 100);
        e = sbq.pop_front();
        chk({tag, " latency"},  lat, e.lat);
        chk({tag, " Result"},   bus.Result, e.res);
        chk({tag, " Overflow"}, {31'h0, bus.Overflow}, {31'h0, e.ovf});
        chk({tag, " CarryOut"}, {31'h0, bus.CarryOut}, {31'h0, e.cout});
        chk({tag, " Zero"},     {31'h0, bus.Zero}, {31'h0, e.zero});
        chk({tag, " busy in_ready"}, {31'h0, rdy_leak}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, " out_valid after handshake"}, {31'h0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ops [14];
        bit   seen;
        ops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_SLTU, OP_SUB, OP_SLT,
                OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_MULHU, 4'b1111};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.ALUop = '0;

        tbl.push_back(mk(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1));
        tbl.push_back(mk(OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1));
        tbl.push_back(mk(OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SLL,   32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_NOR,   32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_SRL,   32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1));
        tbl.push_back(mk(OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1));
        tbl.push_back(mk(OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'b1111,  32'h00000005, 32'h00000006, 32'h00000000, 1'b0, 1'b0, 1));
        tbl.push_back(mk(4'b1011,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1));
        tbl.push_back(mk(OP_MUL,   32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 1'b0, 33));
        tbl.push_back(mk(OP_MULHU, 32'h12345678, 32'h00000010, 32'h00000001, 1'b0, 1'b0, 33));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset out_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("reset in_ready",  {31'h0, bus.in_ready},  32'd1);
        chk("reset Result",    bus.Result, 32'h0);
        chk("reset Zero",      {31'h0, bus.Zero}, 32'd1);
        chk("reset Overflow",  {31'h0, bus.Overflow}, 32'd0);
        chk("reset CarryOut",  {31'h0, bus.CarryOut}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold out_ready low for 5 cycles while a second op waits.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.A = 32'd3; bus.B = 32'd4; bus.ALUop = OP_ADD;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.A = 32'd10; bus.B = 32'd3; bus.ALUop = OP_SUB;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("bp hold%0d out_valid", i), {31'h0, bus.out_valid}, 32'd1);
            chk($sformatf("bp hold%0d Result", i), bus.Result, 32'd7);
            chk($sformatf("bp hold%0d in_ready", i), {31'h0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp after handshake out_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("bp after handshake in_ready", {31'h0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp second out_valid", {31'h0, bus.out_valid}, 32'd1);
        chk("bp second Result", bus.Result, 32'd7);
        chk("bp second CarryOut", {31'h0, bus.CarryOut}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bp second drained", {31'h0, bus.out_valid}, 32'd0);

        // Reset during MULT aborts the multiply.
        bus.in_valid = 1'b1; bus.A = 32'd3; bus.B = 32'd5; bus.ALUop = OP_MUL;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort pre-reset in_ready", {31'h0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort out_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("abort Result", bus.Result, 32'h0);
        chk("abort Zero", {31'h0, bus.Zero}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort in_ready after release", {31'h0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort no stray result", {31'h0, seen}, 32'd0);

        // Random ops against the model.
        for (int i = 0; i < 16; i++) begin
            vec_t v;
            v = model(ops[$urandom_range(0, 13)], $urandom, $urandom);
            run_op(v, $sformatf("rnd%0d op%b", i, v.op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the successor to the single-cycle 32-bit ALU in the CPU datapath. Keeps the AND/OR/ADD/SUB/SLT encodings and flag semantics. Adds XOR/NOR/SLTU, shifts and an iterative unsigned multiplier. Operands are accepted and results returned through valid/ready handshakes, so the execute stage can stall on long operations.

## Interface
- `WIDTH`, 32: operand/result width; power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived, not overridden).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `in_valid`  in  1  operands and opcode valid.
- `in_ready`  out  1  block can accept an operation.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B; `B[SHW-1:0]` is the shift amount for shifts.
- `ALUop`  in  4  opcode.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes result.
- `Result`  out  WIDTH  result.
- `Overflow`  out  1  signed overflow (ADD/SUB only).
- `CarryOut`  out  1  carry out of adder (ADD/SUB only).
- `Zero`  out  1  `Result == 0`.

## Operation
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0011 XOR, 0100 NOR, 0101 SLTU.
  - 1000 SLL, 1001 SRL, 1010 SRA.
  - 1100 MUL (low WIDTH bits of A×B), 1101 MULHU (high WIDTH bits of unsigned A×B).
  - Any other code is illegal.
- ADD: `{CarryOut,Result} = A+B`; Overflow = sign(A)==sign(B) && sign(Result)!=sign(A).
- SUB: `{CarryOut,Result} = A+~B+1`; Overflow = sign(A)!=sign(B) && sign(Result)!=sign(A).
- SLT/SLTU: Result = {0…,1} if A<B (signed/unsigned), else 0.
- Overflow/CarryOut are 0 for every op other than ADD/SUB.
- Zero is computed from the final Result for every op, including illegal ones.
- Illegal op: Result 0, Zero 1, Overflow 0, CarryOut 0, latency as a single-cycle op.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, latch A/B/op. MUL/MULHU → MULT; every other op computes its result into the output registers → DONE.
  - MULT: one shift-add step per cycle; WIDTH-step counter; on the last step write the product half and flags → DONE.
  - DONE: `out_valid`=1 with outputs held stable; on `out_ready` → IDLE.
- One operation in flight. `in_ready`=0 in MULT and DONE. Inputs are ignored while `in_ready`=0.
- MUL datapath: 2·WIDTH accumulator, shifted multiplicand, shifted multiplier; unsigned.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State → IDLE, counter 0.
  - `out_valid`=0; Result, Overflow, CarryOut = 0; Zero = 1 (Result is 0).
  - `in_ready`=1 from the first cycle after reset release.
- Reset during MULT or DONE aborts the operation; no result is produced.
- Handshake at edge k (IDLE, `in_valid`=1) →
  - single-cycle op: `out_valid`=1 after edge k+1.
  - MUL/MULHU: `out_valid`=1 after edge k+WIDTH+1.
- `out_valid` and `out_ready` both high at edge j → IDLE after j; the next accept is possible at j+1. Peak throughput: one op per 2 cycles.
- `out_ready` may be held high permanently. `out_valid` never drops without a handshake, except on reset.
- No combinational path from inputs to `out_valid` or `Result`; `in_ready` is a function of state only.

## Structure
- `alu_pkg`: 4-bit opcode localparams (`OP_AND` … `OP_MULHU`) and the state enum (IDLE/MULT/DONE).
- Sub-module `alu_mul_iter`, parametrised by WIDTH:
  - Inputs: start, A, B. Outputs: done pulse, 2·WIDTH product.
  - Owns the step counter.
- `alu_mc` holds the FSM, the combinational single-cycle unit and the output registers.

## Test plan
- ADD, WIDTH=32: A=0x7FFFFFFF, B=1 → Result 0x80000000, Overflow 1, CarryOut 0, Zero 0, `out_valid` one cycle after accept.
- SUB: A=5, B=5 → Result 0, Zero 1, CarryOut 1, Overflow 0. SLT A=0xFFFFFFFF, B=1 → Result 1; SLTU with the same operands → Result 0.
- SRA: A=0x80000000, B=0x24 (shift 4) → Result 0xF8000000. SLL by 0 → Result = A.
- MULHU: A=0xFFFFFFFF, B=0xFFFFFFFF → Result 0xFFFFFFFE. MUL with the same operands → Result 1. `out_valid` exactly 33 cycles after accept; `in_ready`=0 throughout.
- Backpressure: `out_ready`=0 for 5 cycles while a second `in_valid` is presented → outputs stable, second op not accepted until the cycle after the handshake.
- `rst_n`=0 mid-MULT (cycle 10) → next cycle `out_valid`=0, Result 0, `in_ready`=1 after release. Illegal op 1111 → Result 0, Zero 1.
